// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word host.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_word_host_if.sv
// Word-level and serial signals of the UART word host.
//
// Handshakes: a word moves across tx_valid/tx_ready or rx_valid/rx_ready
// only on a rising clk edge where both are 1. The sender holds valid and its
// data stable until that edge; ready may be asserted independently of valid.
// tx_state / rx_state expose the FSM states for observation only.
interface uart_word_host_if;
  import uart_pkg::*;

  logic [31:0] tx_word;
  logic        tx_valid;
  logic        tx_ready;
  logic        txd;
  logic        rxd;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        rx_ready;
  logic        frame_err;
  logic        overrun;
  tx_state_e   tx_state;
  rx_state_e   rx_state;

  modport slave (
    input  tx_word, tx_valid, rxd, rx_ready,
    output tx_ready, txd, rx_word, rx_valid, frame_err, overrun,
           tx_state, rx_state
  );

  modport master (
    output tx_word, tx_valid, rxd, rx_ready,
    input  tx_ready, txd, rx_word, rx_valid, frame_err, overrun,
           tx_state, rx_state
  );
endinterface

// File: rtl/uart_rx_byte.sv
// Receives one UART byte: synchronizer, mid-bit sampling FSM, stop check.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output rx_state_e  state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync_q, sync_d;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;
  logic          rxs;

  assign rxs = sync_q[1];

  // State registers; synchronizer resets to idle-high so reset looks like a quiet line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state: confirm start at half bit, then sample every full bit period.
  always_comb begin
    sync_d  = {sync_q[0], rxd};
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          sh_d  = {sh_q[6:0], rxs};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxs) begin
            bv_d    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        if (rxs) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = bv_q;
  assign rx_byte    = sh_q;
  assign frame_err  = fe_q;
  assign state_dbg  = state_q;

endmodule

// File: rtl/uart_word_host.sv
// UART word host: sends and receives 32-bit words as four MSB-first frames.
module uart_word_host
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_word_host_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [1:0]    tx_byte_q, tx_byte_d;
  logic [31:0]   tx_sh_q, tx_sh_d;
  logic          txd_q, txd_d;

  logic [31:0]   rx_word_q, rx_word_d;
  logic          rx_valid_q, rx_valid_d;
  logic [23:0]   rx_part_q, rx_part_d;
  logic [1:0]    rx_cnt_q, rx_cnt_d;
  logic          overrun_q, overrun_d;

  logic          rx_byte_valid;
  logic [7:0]    rx_byte;
  logic          rx_frame_err;
  rx_state_e     rx_state_dbg;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (bus.rxd),
    .byte_valid(rx_byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_frame_err),
    .state_dbg (rx_state_dbg)
  );

  // State registers for the transmitter and the receive word assembler.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_byte_q  <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_part_q  <= '0;
      rx_cnt_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_byte_q  <= tx_byte_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_word_q  <= rx_word_d;
      rx_valid_q <= rx_valid_d;
      rx_part_q  <= rx_part_d;
      rx_cnt_q   <= rx_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  // TX next-state: txd_d is the level of the bit the next state will drive.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_sh_d    = bus.tx_word;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_byte_d  = '0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          txd_d      = tx_sh_q[31];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        txd_d = tx_sh_q[31];
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_d = '0;
          tx_sh_d  = {tx_sh_q[30:0], 1'b0};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            txd_d    = tx_sh_q[30];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        txd_d = 1'b1;
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_d = '0;
          if (tx_byte_q == LAST_BYTE) begin
            tx_byte_d  = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_state_d = TX_START;
            txd_d      = 1'b0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX word assembly: collect four good bytes, hand off or flag overrun.
  always_comb begin
    rx_word_d  = rx_word_q;
    rx_valid_d = rx_valid_q;
    rx_part_d  = rx_part_q;
    rx_cnt_d   = rx_cnt_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
    if (rx_frame_err) begin
      rx_cnt_d  = '0;
      rx_part_d = '0;
    end else if (rx_byte_valid) begin
      rx_part_d = {rx_part_q[15:0], rx_byte};
      if (rx_cnt_q == LAST_BYTE) begin
        rx_cnt_d  = '0;
        rx_part_d = '0;
        if (!rx_valid_q || bus.rx_ready) begin
          rx_word_d  = {rx_part_q, rx_byte};
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + 2'd1;
      end
    end
  end

  assign bus.tx_ready  = (tx_state_q == TX_IDLE) && !rst;
  assign bus.txd       = txd_q;
  assign bus.rx_word   = rx_word_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = rx_frame_err;
  assign bus.overrun   = overrun_q;
  assign bus.tx_state  = tx_state_q;
  assign bus.rx_state  = rx_state_dbg;

endmodule

// File: tb/tb_uart_word_host.sv
// Bench for uart_word_host: TX bit-level checks plus an RX word scoreboard.
module tb_uart_word_host;
  import uart_pkg::*;

  localparam int C = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_word_host_if bus();
  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;
  assign bus.rxd = loop_en ? bus.txd : rxd_drv;

  uart_word_host #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: level of serial bit n of a word (10-bit frames, MSB-first bytes).
  function automatic logic tx_bit(input logic [31:0] w, input int n);
    logic [7:0] b;
    int j;
    b = 8'(w >> (8 * (3 - n / 10)));
    j = n % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[8 - j];
  endfunction

  // Monitor: pops the scoreboard on every rx handshake, counts flag pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) fe_seen++;
      if (bus.overrun)   ov_seen++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected actual=%h required=none", bus.rx_word);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_word", bus.rx_word, mon_exp);
        end
      end
    end
  end

  // Driver: send one word through the TX port and check every serial cycle.
  task automatic send_tx(input logic [31:0] w, input bit expect_rx);
    check("tx_ready_pre", {31'b0, bus.tx_ready}, 32'd1);
    bus.tx_word  = w;
    bus.tx_valid = 1'b1;
    if (expect_rx) exp_q.push_back(w);
    @(posedge clk); #1;
    bus.tx_valid = 1'($urandom_range(0, 1));
    bus.tx_word  = $urandom;
    for (int i = 0; i < 40 * C; i++) begin
      @(negedge clk);
      check("txd", {31'b0, bus.txd}, {31'b0, tx_bit(w, i / C)});
      check("tx_ready_busy", {31'b0, bus.tx_ready}, 32'd0);
    end
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check("tx_ready_done", {31'b0, bus.tx_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic ser_bit(input logic v);
    rxd_drv = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic ser_byte(input logic [7:0] b, input logic stop);
    ser_bit(1'b0);
    for (int j = 7; j >= 0; j--) ser_bit(b[j]);
    ser_bit(stop);
  endtask

  task automatic ser_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ser_byte(8'(w >> (8 * (3 - k))), 1'b1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic check_flags(input string name);
    check({name, "_frame_err"}, fe_seen, fe_exp);
    check({name, "_overrun"}, ov_seen, ov_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1, w2;
    bus.tx_word  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", {31'b0, bus.txd}, 32'd1);
    check("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
    check("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("rst_frame_err", {31'b0, bus.frame_err}, 32'd0);
    check("rst_overrun", {31'b0, bus.overrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
    check("post_rst_rx_word", bus.rx_word, 32'd0);
    @(posedge clk); #1;

    // TX frame timing, line not looped back
    send_tx(32'hA5C3_0F81, 1'b0);

    // Loopback words
    loop_en = 1'b1;
    send_tx(32'hDEAD_BEEF, 1'b1);
    drain("drain_deadbeef");
    check_flags("loop");
    for (int i = 0; i < 4; i++) begin
      send_tx($urandom, 1'b1);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
    end
    drain("drain_loop_rand");
    loop_en = 1'b0;

    // Bad stop bit after a partial word, then a good word
    ser_byte(8'hAA, 1'b1);
    ser_byte(8'h3C, 1'b0);
    fe_exp++;
    ser_bit(1'b1);
    exp_q.push_back(32'h1234_5678);
    ser_word(32'h1234_5678);
    drain("drain_frame_err");
    check_flags("frame_err");

    // Overrun with consumer stalled
    bus.rx_ready = 1'b0;
    w1 = $urandom;
    w2 = $urandom;
    exp_q.push_back(w1);
    ser_word(w1);
    ser_word(w2);
    ov_exp++;
    repeat (10) @(posedge clk);
    #1;
    check("ovr_rx_valid", {31'b0, bus.rx_valid}, 32'd1);
    check("ovr_rx_word", bus.rx_word, w1);
    check_flags("overrun");
    bus.rx_ready = 1'b1;
    drain("drain_overrun");

    // One-cycle glitch on an idle line
    rxd_drv = 1'b0;
    @(posedge clk); #1;
    rxd_drv = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("glitch_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("glitch_rx_state", 32'(bus.rx_state), 32'(RX_IDLE));
    check_flags("glitch");
    w1 = $urandom;
    exp_q.push_back(w1);
    ser_word(w1);
    drain("drain_glitch");

    // Reset in the middle of a looped-back word
    loop_en = 1'b1;
    bus.tx_word  = $urandom;
    bus.tx_valid = 1'b1;
    @(posedge clk); #1;
    bus.tx_valid = 1'b0;
    repeat ($urandom_range(20, 120)) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_txd", {31'b0, bus.txd}, 32'd1);
    check("midrst_tx_ready", {31'b0, bus.tx_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("midrst_rx_word", bus.rx_word, 32'd0);
    check("midrst_tx_ready_after", {31'b0, bus.tx_ready}, 32'd1);
    @(posedge clk); #1;
    send_tx($urandom, 1'b1);
    drain("drain_midrst");
    check_flags("midrst");
    loop_en = 1'b0;

    // TX and RX running at the same time on independent lines
    w1 = $urandom;
    w2 = $urandom;
    exp_q.push_back(w2);
    fork
      send_tx(w1, 1'b0);
      ser_word(w2);
    join
    drain("drain_concurrent");
    check_flags("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_word_host.md
UART_WORD_HOST -- requirements
Module: uart_word_host

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per UART bit; legal values are >= 4 and even.
REQ-002 The block SHALL have one clock and synchronous active-high reset; ports are named clk and rst.
REQ-003 Port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port tx_word, input, 32 bits: word to transmit.
REQ-006 Port tx_valid, input, 1 bit: tx_word valid.
REQ-007 Port tx_ready, output, 1 bit: transmitter idle and able to accept a word.
REQ-008 Port txd, output, 1 bit: serial output, idle high.
REQ-009 Port rxd, input, 1 bit: asynchronous serial input, idle high.
REQ-010 Port rx_word, output, 32 bits: last assembled received word.
REQ-011 Port rx_valid, output, 1 bit: rx_word holds an unconsumed word.
REQ-012 Port rx_ready, input, 1 bit: consumer accepts rx_word.
REQ-013 Port frame_err, output, 1 bit: one-cycle pulse when a bad stop bit is sampled.
REQ-014 Port overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-015 Each frame SHALL be 10 bits, each CLKS_PER_BIT cycles long: start bit 0, 8 data bits MSB-first, stop bit 1.
REQ-016 A word SHALL be 4 consecutive frames, byte [31:24] first and [7:0] last, in both directions.
REQ-017 TX states SHALL be IDLE, START, DATA, STOP; IDLE drives txd=1 and tx_ready=1.
REQ-018 When tx_valid && tx_ready is true, the block SHALL latch tx_word, move to START on the next cycle, and drop tx_ready.
REQ-019 txd SHALL be registered; the first start bit appears on the cycle after acceptance.
REQ-020 After a byte's STOP, the next byte's START SHALL follow with no idle gap.
REQ-021 After the fourth STOP, TX SHALL return to IDLE; tx_ready=1 exactly 40*CLKS_PER_BIT cycles after acceptance.
REQ-022 tx_valid while tx_ready=0 SHALL be ignored; tx_word changes during transmission SHALL have no effect.
REQ-023 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-024 RX states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-025 In IDLE, synchronized rxd=0 SHALL enter START.
REQ-026 In START, rxd SHALL be re-sampled after CLKS_PER_BIT/2 cycles; 0 goes to DATA, 1 returns to IDLE (glitch, no flags raised).
REQ-027 In DATA, rxd SHALL be sampled every CLKS_PER_BIT cycles (mid-bit), 8 samples, shifted left (first bit becomes MSB).
REQ-028 In STOP, rxd SHALL be sampled mid-bit; 1 appends the byte to the word and increments a 2-bit byte counter, then goes to IDLE.
REQ-029 A stop sample of 0 SHALL pulse frame_err, discard the byte and any partial word (byte counter := 0), and go to WAIT_IDLE.
REQ-030 WAIT_IDLE SHALL return to IDLE only when synchronized rxd=1.
REQ-031 On the 4th good byte, the block SHALL load rx_word and set rx_valid=1 on the next cycle, and wrap the byte counter to 0.
REQ-032 rx_valid SHALL clear on the cycle after rx_valid && rx_ready, unless a new word loads on that same cycle, in which case rx_word updates and rx_valid stays 1.
REQ-033 A word completing while rx_valid=1 and rx_ready=0 SHALL be dropped, rx_word kept unchanged, and overrun pulsed for one cycle.
REQ-034 TX and RX SHALL operate concurrently and independently.

Reset
REQ-035 Reset SHALL force txd=1, tx_ready=0 during rst then 1 on the first cycle after, rx_valid=0, rx_word=0, frame_err=0, overrun=0, both FSMs to IDLE, all counters to 0, and synchronizer flops to 1.
REQ-036 Reset mid-frame SHALL abort the frame and discard latched and partial data, with no flags raised.

Structure
REQ-037 Package uart_pkg SHALL hold tx_state_e, rx_state_e, FRAME_BITS=10, BYTES_PER_WORD=4.
REQ-038 Byte reception (synchronizer, RX FSM, mid-bit timer) SHALL be sub-module uart_rx_byte, which reports byte_valid, byte, and frame_err.

Verification (CLKS_PER_BIT=4)
REQ-039 Reset: rst=1 for 2 cycles with rxd=1 -> txd=1, rx_valid=0, frame_err=0, overrun=0; tx_ready=1 on the first cycle after reset.
REQ-040 TX 32'hA5C3_0F81 -> first frame on txd is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, and tx_ready=1 160 cycles after acceptance.
REQ-041 Loopback txd->rxd, send 32'hDEAD_BEEF with rx_ready=1 -> one rx_valid pulse with rx_word=32'hDEAD_BEEF and no flags.
REQ-042 Inject byte 8'h3C with stop=0, then a good word 32'h1234_5678 -> one frame_err pulse, then rx_word=32'h1234_5678.
REQ-043 Send two words with rx_ready=0 -> rx_word keeps the first, overrun pulses once, rx_valid stays 1.
REQ-044 Drive rxd=0 for 1 cycle in idle -> no reception, no flags, next word received correctly.
